// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the MEM/WB pipeline slice.
//   DATA_W      default datapath width
//   REG_ADDR_W  register-file address width
//   mem_state_e memory-access FSM encoding (IDLE, WAIT)
package mips_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/data_mem.sv
// data_mem: word-addressed data memory, synchronous write / asynchronous read.
// Contents are intentionally not reset.
//   clk    rising-edge write clock
//   we     write enable, sampled on clk
//   addr   word address (wraps modulo DEPTH)
//   wdata  write data
//   rdata  combinational read data at addr
module data_mem #(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned DEPTH  = 64,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MIPS memory stage with a multi-cycle data memory and the
// MEM/WB pipeline register.
//   CLK, RST                 clock (rising edge), async active-high reset
//   ALUOutM, WriteDataM      address / ALU result, store data
//   WriteRegM                destination register
//   RegWriteM, MemtoRegM,
//   MemWriteM                control; MemtoRegM = load, MemWriteM = store
//   StallM                   high while a memory access is still in progress
//   ReadDataW, ALUOutW,
//   WriteRegW, RegWriteW,
//   MemtoRegW                writeback register outputs
//   AlignErrW                one-cycle misalignment flag (MISALIGN_TRAP_EN only)
// Optional feature macro: MISALIGN_TRAP_EN (misaligned accesses are trapped:
// no memory write, no register write, AlignErrW pulses at writeback).
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W  = mips_pkg::DATA_W,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_W-1:0]     ALUOutM,
  input  logic [DATA_W-1:0]     WriteDataM,
  input  logic [REG_ADDR_W-1:0] WriteRegM,
  input  logic                  RegWriteM,
  input  logic                  MemtoRegM,
  input  logic                  MemWriteM,
  output logic                  StallM,
  output logic [DATA_W-1:0]     ReadDataW,
  output logic [DATA_W-1:0]     ALUOutW,
  output logic [REG_ADDR_W-1:0] WriteRegW,
  output logic                  RegWriteW,
`ifdef MISALIGN_TRAP_EN
  output logic                  AlignErrW,
`endif
  output logic                  MemtoRegW
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (MEM_LAT > 0) ? CNT_W'(MEM_LAT - 1) : '0;

  mem_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [DATA_W-1:0]     read_data_q, read_data_d;
  logic [DATA_W-1:0]     alu_out_q, alu_out_d;
  logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
  logic                  reg_write_q, reg_write_d;
  logic                  mem_to_reg_q, mem_to_reg_d;
`ifdef MISALIGN_TRAP_EN
  logic                  align_err_q, align_err_d;
`endif

  logic                  req;
  logic                  stall;
  logic                  misalign;
  logic                  mem_we;
  logic [DATA_W-1:0]     rdata;

  assign req = MemtoRegM | MemWriteM;

`ifdef MISALIGN_TRAP_EN
  assign misalign = req & (ALUOutM[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Access FSM: the request cycle plus MEM_LAT-1 WAIT cycles stall; the
  // WAIT cycle with cnt==0 is the completing cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req && (MEM_LAT != 0)) begin
          stall   = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          stall = 1'b1;
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // StallM is combinational, so force it low while reset is held.
    if (RST) begin
      stall = 1'b0;
    end
  end

  // Gating with RST keeps an access aborted by reset from writing memory.
  assign mem_we = MemWriteM & ~stall & ~misalign & ~RST;

  data_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_data_mem (
    .clk   (CLK),
    .we    (mem_we),
    .addr  (ALUOutM[ADDR_W+1:2]),
    .wdata (WriteDataM),
    .rdata (rdata)
  );

  // Writeback register: stalled edges insert a bubble (control cleared,
  // data fields held); completing edges capture the instruction.
  always_comb begin
    read_data_d  = read_data_q;
    alu_out_d    = alu_out_q;
    write_reg_d  = write_reg_q;
    reg_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
`ifdef MISALIGN_TRAP_EN
    align_err_d  = 1'b0;
`endif
    if (!stall) begin
      read_data_d  = rdata;
      alu_out_d    = ALUOutM;
      write_reg_d  = WriteRegM;
      reg_write_d  = RegWriteM & ~misalign;
      mem_to_reg_d = MemtoRegM;
`ifdef MISALIGN_TRAP_EN
      align_err_d  = misalign;
`endif
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      read_data_q  <= '0;
      alu_out_q    <= '0;
      write_reg_q  <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      align_err_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      read_data_q  <= read_data_d;
      alu_out_q    <= alu_out_d;
      write_reg_q  <= write_reg_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
`ifdef MISALIGN_TRAP_EN
      align_err_q  <= align_err_d;
`endif
    end
  end

  assign StallM    = stall;
  assign ReadDataW = read_data_q;
  assign ALUOutW   = alu_out_q;
  assign WriteRegW = write_reg_q;
  assign RegWriteW = reg_write_q;
  assign MemtoRegW = mem_to_reg_q;
`ifdef MISALIGN_TRAP_EN
  assign AlignErrW = align_err_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed self-checking bench for mem_wb_stage
// (DATA_W=32, DEPTH=64, MEM_LAT=2). Inputs change 1 time unit after the
// rising edge; outputs are sampled 1-2 time units after the edge.
module tb_mem_wb_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] ALUOutM = '0;
  logic [31:0] WriteDataM = '0;
  logic [4:0]  WriteRegM = '0;
  logic        RegWriteM = 1'b0;
  logic        MemtoRegM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic        StallM;
  logic [31:0] ReadDataW;
  logic [31:0] ALUOutW;
  logic [4:0]  WriteRegW;
  logic        RegWriteW;
  logic        MemtoRegW;
`ifdef MISALIGN_TRAP_EN
  logic        AlignErrW;
`endif

  int vectors    = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  mem_wb_stage #(
    .DATA_W  (32),
    .DEPTH   (64),
    .MEM_LAT (2)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .WriteRegM  (WriteRegM),
    .RegWriteM  (RegWriteM),
    .MemtoRegM  (MemtoRegM),
    .MemWriteM  (MemWriteM),
    .StallM     (StallM),
    .ReadDataW  (ReadDataW),
    .ALUOutW    (ALUOutW),
    .WriteRegW  (WriteRegW),
    .RegWriteW  (RegWriteW),
`ifdef MISALIGN_TRAP_EN
    .AlignErrW  (AlignErrW),
`endif
    .MemtoRegW  (MemtoRegW)
  );

  task automatic drive(input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] wr, input logic rw,
                       input logic m2r, input logic mw);
    ALUOutM    = alu;
    WriteDataM = wd;
    WriteRegM  = wr;
    RegWriteM  = rw;
    MemtoRegM  = m2r;
    MemWriteM  = mw;
  endtask

  task automatic drive_nop();
    drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Holds the presented instruction until its completing edge. Called at
  // edge+1; returns at edge+1 after the completing edge. Counts stalled
  // cycles and RegWriteW=1 observations following stalled edges.
  task automatic run_to_completion(output int stalls, output int rw_during,
                                   output bit timeout);
    stalls    = 0;
    rw_during = 0;
    timeout   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (StallM === 1'b1) begin
        stalls++;
        @(posedge CLK); #1;
        if (RegWriteW !== 1'b0) rw_during++;
      end else begin
        @(posedge CLK); #1;
        timeout = 1'b0;
        return;
      end
    end
  endtask

  task automatic test_reset();
    // Request presented while in reset: StallM must stay low.
    drive(32'h20, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0);
    #2;
    vectors++; if (StallM !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %0b want 0", StallM); end
    vectors++; if (ReadDataW !== 32'h0) begin miscompares++; $display("FAIL reset_readdata: got %h want 0", ReadDataW); end
    vectors++; if (ALUOutW !== 32'h0) begin miscompares++; $display("FAIL reset_aluout: got %h want 0", ALUOutW); end
    vectors++; if (WriteRegW !== 5'd0) begin miscompares++; $display("FAIL reset_writereg: got %0d want 0", WriteRegW); end
    vectors++; if (RegWriteW !== 1'b0) begin miscompares++; $display("FAIL reset_regwrite: got %0b want 0", RegWriteW); end
    vectors++; if (MemtoRegW !== 1'b0) begin miscompares++; $display("FAIL reset_memtoreg: got %0b want 0", MemtoRegW); end
    @(posedge CLK); #1;
    drive_nop();
    RST = 1'b0;
  endtask

  task automatic test_alu_op();
    int s, r; bit to;
    drive(32'h5, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0);
    run_to_completion(s, r, to);
    vectors++; if (to || s != 0) begin miscompares++; $display("FAIL alu_stall: got %0d stalls (timeout %0b) want 0", s, to); end
    vectors++; if (ALUOutW !== 32'h5) begin miscompares++; $display("FAIL alu_aluout: got %h want 5", ALUOutW); end
    vectors++; if (WriteRegW !== 5'd3) begin miscompares++; $display("FAIL alu_writereg: got %0d want 3", WriteRegW); end
    vectors++; if (RegWriteW !== 1'b1) begin miscompares++; $display("FAIL alu_regwrite: got %0b want 1", RegWriteW); end
    vectors++; if (MemtoRegW !== 1'b0) begin miscompares++; $display("FAIL alu_memtoreg: got %0b want 0", MemtoRegW); end
  endtask

  // Store then load presented back to back: the load starts the cycle after
  // the store completes.
  task automatic test_back_to_back();
    int s, r; bit to;
    drive(32'h20, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b1);
    run_to_completion(s, r, to);
    vectors++; if (to || s != 2) begin miscompares++; $display("FAIL store_stall: got %0d stalls (timeout %0b) want 2", s, to); end
    vectors++; if (ALUOutW !== 32'h20) begin miscompares++; $display("FAIL store_aluout: got %h want 20", ALUOutW); end
    vectors++; if (RegWriteW !== 1'b0) begin miscompares++; $display("FAIL store_regwrite: got %0b want 0", RegWriteW); end
    drive(32'h20, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0);
    #1;
    vectors++; if (StallM !== 1'b1) begin miscompares++; $display("FAIL load_first_stall: got %0b want 1", StallM); end
    // Bubble holds the previous data fields.
    @(posedge CLK); #1;
    vectors++; if (ALUOutW !== 32'h20 || RegWriteW !== 1'b0) begin miscompares++; $display("FAIL load_bubble: got alu %h rw %0b want 20 0", ALUOutW, RegWriteW); end
    run_to_completion(s, r, to);
    vectors++; if (to || s != 1) begin miscompares++; $display("FAIL load_stall: got %0d remaining stalls (timeout %0b) want 1", s, to); end
    vectors++; if (r != 0) begin miscompares++; $display("FAIL load_rw_during_stall: got %0d want 0", r); end
    vectors++; if (ReadDataW !== 32'hDEADBEEF) begin miscompares++; $display("FAIL load_readdata: got %h want deadbeef", ReadDataW); end
    vectors++; if (MemtoRegW !== 1'b1) begin miscompares++; $display("FAIL load_memtoreg: got %0b want 1", MemtoRegW); end
    vectors++; if (RegWriteW !== 1'b1 || WriteRegW !== 5'd7) begin miscompares++; $display("FAIL load_writeback: got rw %0b reg %0d want 1 7", RegWriteW, WriteRegW); end
    drive_nop();
    @(posedge CLK); #1;
    vectors++; if (RegWriteW !== 1'b0 || MemtoRegW !== 1'b0) begin miscompares++; $display("FAIL load_single_writeback: got rw %0b m2r %0b want 0 0", RegWriteW, MemtoRegW); end
  endtask

  task automatic test_wrap();
    int s, r; bit to;
    drive(32'h100, 32'h1, 5'd0, 1'b0, 1'b0, 1'b1);
    run_to_completion(s, r, to);
    drive(32'h0, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0);
    run_to_completion(s, r, to);
    vectors++; if (to || s != 2) begin miscompares++; $display("FAIL wrap_stall: got %0d stalls (timeout %0b) want 2", s, to); end
    vectors++; if (ReadDataW !== 32'h1) begin miscompares++; $display("FAIL wrap_readdata: got %h want 1", ReadDataW); end
    drive_nop();
  endtask

  task automatic test_reset_mid_access();
    int s, r; bit to;
    drive(32'h10, 32'h11111111, 5'd0, 1'b0, 1'b0, 1'b1);
    run_to_completion(s, r, to);
    drive(32'h10, 32'h22222222, 5'd0, 1'b0, 1'b0, 1'b1);
    #1;
    vectors++; if (StallM !== 1'b1) begin miscompares++; $display("FAIL rst_mid_pre_stall: got %0b want 1", StallM); end
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    vectors++; if (StallM !== 1'b0) begin miscompares++; $display("FAIL rst_mid_stall: got %0b want 0", StallM); end
    vectors++; if (ReadDataW !== 32'h0 || ALUOutW !== 32'h0 || WriteRegW !== 5'd0 || RegWriteW !== 1'b0 || MemtoRegW !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got rd %h alu %h reg %0d rw %0b m2r %0b want all 0", ReadDataW, ALUOutW, WriteRegW, RegWriteW, MemtoRegW);
    end
    drive(32'h10, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0);
    @(posedge CLK); #1;
    RST = 1'b0;
    run_to_completion(s, r, to);
    vectors++; if (to || s != 2) begin miscompares++; $display("FAIL rst_restart_stall: got %0d stalls (timeout %0b) want 2", s, to); end
    vectors++; if (ReadDataW !== 32'h11111111) begin miscompares++; $display("FAIL rst_prior_value: got %h want 11111111", ReadDataW); end
    drive_nop();
  endtask

`ifdef MISALIGN_TRAP_EN
  task automatic test_misalign();
    int s, r; bit to;
    drive(32'h22, 32'h12345678, 5'd5, 1'b1, 1'b0, 1'b1);
    run_to_completion(s, r, to);
    vectors++; if (to || s != 2) begin miscompares++; $display("FAIL mis_stall: got %0d stalls (timeout %0b) want 2", s, to); end
    vectors++; if (AlignErrW !== 1'b1) begin miscompares++; $display("FAIL mis_alignerr: got %0b want 1", AlignErrW); end
    vectors++; if (RegWriteW !== 1'b0) begin miscompares++; $display("FAIL mis_regwrite: got %0b want 0", RegWriteW); end
    drive(32'h20, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0);
    #1;
    @(posedge CLK); #1;
    vectors++; if (AlignErrW !== 1'b0) begin miscompares++; $display("FAIL mis_pulse_width: got %0b want 0", AlignErrW); end
    run_to_completion(s, r, to);
    vectors++; if (ReadDataW !== 32'hDEADBEEF) begin miscompares++; $display("FAIL mis_mem_unchanged: got %h want deadbeef", ReadDataW); end
    drive_nop();
  endtask
`else
  task automatic test_low_bits_ignored();
    int s, r; bit to;
    drive(32'h2A, 32'hCAFEF00D, 5'd0, 1'b0, 1'b0, 1'b1);
    run_to_completion(s, r, to);
    drive(32'h28, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0);
    run_to_completion(s, r, to);
    vectors++; if (ReadDataW !== 32'hCAFEF00D) begin miscompares++; $display("FAIL low_bits_readdata: got %h want cafef00d", ReadDataW); end
    vectors++; if (RegWriteW !== 1'b1) begin miscompares++; $display("FAIL low_bits_regwrite: got %0b want 1", RegWriteW); end
    drive_nop();
  endtask
`endif

  initial begin
    test_reset();
    test_alu_op();
    test_back_to_back();
    test_wrap();
    test_reset_mid_access();
`ifdef MISALIGN_TRAP_EN
    test_misalign();
`else
    test_low_bits_ignored();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 The block SHALL have these parameters: DATA_W, default 32, datapath width; DEPTH, default 64, data-memory words; MEM_LAT, default 2, wait cycles per memory access (0 = single-cycle).
REQ-002 The block SHALL have these ports, clock and reset first: CLK input 1, one clock, rising edge; RST input 1, reset, asynchronous and active-high.
REQ-003 The block SHALL have these memory-stage inputs: ALUOutM input DATA_W, address or ALU result; WriteDataM input DATA_W, store data; WriteRegM input 5, destination register.
REQ-004 The block SHALL have these control inputs, each 1 bit: RegWriteM, MemtoRegM (load), MemWriteM (store).
REQ-005 The block SHALL have StallM, output 1, asserted while a memory access is incomplete and upstream holds its inputs.
REQ-006 The block SHALL have these writeback outputs: ReadDataW output DATA_W; ALUOutW output DATA_W; WriteRegW output 5; RegWriteW output 1; MemtoRegW output 1.
REQ-007 The block SHALL have AlignErrW, output 1, a one-cycle misalignment flag that exists only with the macro in REQ-023.

Function
REQ-008 A request SHALL be defined as MemtoRegM or MemWriteM high; non-memory instructions SHALL pass in one cycle with StallM=0.
REQ-009 The memory word address SHALL be ALUOutM[log2(DEPTH)+1:2]; higher address bits SHALL be ignored, so accesses wrap modulo DEPTH.
REQ-010 The FSM SHALL have two states, IDLE and WAIT, and a counter wide enough for MEM_LAT.
REQ-011 IDLE with a request and MEM_LAT>0: StallM=1, load cnt=MEM_LAT-1, go to WAIT.
REQ-012 WAIT with cnt!=0: StallM=1, decrement cnt, stay in WAIT.
REQ-013 WAIT with cnt==0: StallM=0, complete the access on that edge, return to IDLE.
REQ-014 A memory access SHALL occupy exactly MEM_LAT+1 cycles; StallM SHALL be high for the first MEM_LAT cycles only.
REQ-015 With MEM_LAT=0 the FSM SHALL stay in IDLE, StallM SHALL stay 0, and every access SHALL complete in its own cycle.
REQ-016 A store SHALL write WriteDataM exactly once, on the completing edge; no write SHALL occur on stalled edges.
REQ-017 Load read data SHALL come from the array combinationally and be registered into ReadDataW on the completing edge.
REQ-018 On every edge with StallM=1, the writeback register SHALL load a bubble: RegWriteW=0 and MemtoRegW=0, with data fields unchanged.
REQ-019 On every edge with StallM=0, the writeback register SHALL capture ALUOutM, WriteRegM, RegWriteM, MemtoRegM and the read data, giving 1-cycle latency to writeback.
REQ-020 Back-to-back requests SHALL start the next access in the cycle after completion; a store followed by a load to the same address SHALL return the stored data.

Reset
REQ-021 While RST=1, all outputs SHALL be 0, state SHALL be IDLE, cnt SHALL be 0, and memory contents SHALL be left unreset.
REQ-022 Reset asserted mid-access SHALL abort it with no memory write; after release, an access still presented SHALL restart from IDLE with full latency.

Configuration
REQ-023 When MISALIGN_TRAP_EN is defined, a request with ALUOutM[1:0]!=0 SHALL suppress the memory write and the register write (RegWriteW=0), and SHALL pulse AlignErrW for one cycle at writeback, still after MEM_LAT+1 cycles.
REQ-024 When MISALIGN_TRAP_EN is undefined, ALUOutM[1:0] SHALL be ignored and the AlignErrW port SHALL be absent.

Structure
REQ-025 Shared package mips_pkg SHALL hold DATA_W, REG_ADDR_W=5, and the FSM state encoding.
REQ-026 A sub-module data_mem SHALL hold the array, with synchronous write-enable write and asynchronous read.

Verification
REQ-027 Reset: assert RST mid-WAIT of a store to 0x10 -> no write, all outputs 0; a later load from 0x10 returns its prior value.
REQ-028 MEM_LAT=2: store 0xDEADBEEF to 0x20, then load 0x20 -> StallM high 2 cycles per access; ReadDataW=0xDEADBEEF with MemtoRegW=1 one cycle after the load completes.
REQ-029 ALU op (RegWriteM=1, ALUOutM=0x5, WriteRegM=3) -> next cycle ALUOutW=0x5, WriteRegW=3, RegWriteW=1, StallM never asserted.
REQ-030 During a stalled load -> RegWriteW=0 on every stall edge; exactly one writeback with RegWriteW=1.
REQ-031 DEPTH=64: store 0x1 to address 0x100 -> a load from 0x0 returns 0x1 (wrap).
REQ-032 MISALIGN_TRAP_EN defined: store to 0x22 -> memory unchanged, AlignErrW high for exactly one cycle.
